// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the GateMate CC_PLL: pulses the steady-lock reset, waits for lock with
// timeout and bounded retries, debounces lock, then releases the user reset and watches for loss of lock.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int STDY_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int HOLD_CYCLES     = 16,
    parameter int MAX_RETRIES     = 3,
    localparam int RETRY_W        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               pll_locked_stdy,
    output logic               pll_stdy_rst,
    output logic               sys_rst_out,
    output logic               ready,
    output logic               fail,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [7:0]         lost_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_STDY_RST  = 3'd1;
    localparam logic [2:0] S_WAIT_LOCK = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    localparam int CNT_MAX_A = (STDY_RST_CYCLES > HOLD_CYCLES) ? STDY_RST_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   STDY_LAST    = CNT_W'(STDY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

    logic [SYNC_STAGES-1:0] locked_sync_q, locked_sync_d;
    logic [SYNC_STAGES-1:0] stdy_sync_q, stdy_sync_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [7:0]             lost_q, lost_d;
    logic                   pll_stdy_rst_q, pll_stdy_rst_d;
    logic                   sys_rst_out_q, sys_rst_out_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;
    logic                   locked_s, stdy_s;

    assign locked_s = locked_sync_q[SYNC_STAGES-1];
    assign stdy_s   = stdy_sync_q[SYNC_STAGES-1];

    always_comb begin
        locked_sync_d = {locked_sync_q[SYNC_STAGES-2:0], pll_locked};
        stdy_sync_d   = {stdy_sync_q[SYNC_STAGES-2:0], pll_locked_stdy};
    end

    // One shared cycle counter serves all timed states; it is cleared on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_STDY_RST;
                cnt_d   = '0;
            end
            S_STDY_RST: begin
                if (cnt_q == STDY_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // Lock observed on the timeout cycle takes priority over the retry.
                if (locked_s && stdy_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_STDY_RST;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Only loss of the basic lock re-sequences; a steady-lock drop alone is tolerated.
                if (!locked_s) begin
                    state_d = S_STDY_RST;
                    cnt_d   = '0;
                    if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                retry_d = '0;
                lost_d  = '0;
            end
        endcase
    end

    always_comb begin
        pll_stdy_rst_d = (state_d == S_STDY_RST);
        sys_rst_out_d  = (state_d != S_RUN);
        ready_d        = (state_d == S_RUN);
        fail_d         = (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_sync_q  <= '0;
            stdy_sync_q    <= '0;
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            retry_q        <= '0;
            lost_q         <= '0;
            pll_stdy_rst_q <= 1'b0;
            sys_rst_out_q  <= 1'b1;
            ready_q        <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            locked_sync_q  <= locked_sync_d;
            stdy_sync_q    <= stdy_sync_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            lost_q         <= lost_d;
            pll_stdy_rst_q <= pll_stdy_rst_d;
            sys_rst_out_q  <= sys_rst_out_d;
            ready_q        <= ready_d;
            fail_q         <= fail_d;
        end
    end

    assign pll_stdy_rst = pll_stdy_rst_q;
    assign sys_rst_out  = sys_rst_out_q;
    assign ready        = ready_q;
    assign fail         = fail_q;
    assign state        = state_q;
    assign retry_cnt    = retry_q;
    assign lost_cnt     = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued against absolute cycle numbers
// and a negedge monitor compares them against the DUT outputs of that cycle.
module tb_pll_reset_sequencer;

    localparam int SIG_STATE = 0;
    localparam int SIG_SYSR  = 1;
    localparam int SIG_STDY  = 2;
    localparam int SIG_READY = 3;
    localparam int SIG_FAIL  = 4;
    localparam int SIG_RETRY = 5;
    localparam int SIG_LOST  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_locked_stdy = 1'b0;
    logic       pll_stdy_rst, sys_rst_out, ready, fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;

    pll_reset_sequencer #(
        .SYNC_STAGES(2), .STDY_RST_CYCLES(4), .LOCK_TIMEOUT(64), .HOLD_CYCLES(16), .MAX_RETRIES(3)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_locked_stdy(pll_locked_stdy),
        .pll_stdy_rst(pll_stdy_rst), .sys_rst_out(sys_rst_out), .ready(ready), .fail(fail),
        .state(state), .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic int getSig(input int sig);
        case (sig)
            SIG_STATE: return int'(state);
            SIG_SYSR:  return int'(sys_rst_out);
            SIG_STDY:  return int'(pll_stdy_rst);
            SIG_READY: return int'(ready);
            SIG_FAIL:  return int'(fail);
            SIG_RETRY: return int'(retry_cnt);
            default:   return int'(lost_cnt);
        endcase
    endfunction

    task automatic expectAt(input int c, input int sig, input int val, input string name);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic expectOut(input int c, input int st, input int sysr, input int stdy,
                             input int rdy, input int fl, input string name);
        expectAt(c, SIG_STATE, st, {name, ".state"});
        expectAt(c, SIG_SYSR, sysr, {name, ".sys_rst_out"});
        expectAt(c, SIG_STDY, stdy, {name, ".pll_stdy_rst"});
        expectAt(c, SIG_READY, rdy, {name, ".ready"});
        expectAt(c, SIG_FAIL, fl, {name, ".fail"});
    endtask

    task automatic checkOutput(input exp_t e);
        int act;
        act = getSig(e.sig);
        n_checks++;
        if (act == e.val) n_pass++;
        else $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", e.name, e.cyc, act, e.val);
    endtask

    // Monitor: every cycle, compare and retire all expectations due on this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].cyc == cyc) begin
                checkOutput(sb_q[i]);
                sb_q.delete(i);
            end else if (sb_q[i].cyc < cyc) begin
                n_checks++;
                $display("[TB] FAIL %s @cycle %0d: never sampled, expected %0d",
                         sb_q[i].name, sb_q[i].cyc, sb_q[i].val);
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic l, input logic s);
        rst             = r;
        pll_locked      = l;
        pll_locked_stdy = s;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stepTo(input int c);
        while (cyc < c) step(1);
    endtask

    // Nominal bring-up timing relative to the last cycle with rst high.
    task automatic expectNominal(input int r, input string name);
        expectOut(r + 1, 1, 1, 1, 0, 0, {name, ".e1"});
        expectOut(r + 4, 1, 1, 1, 0, 0, {name, ".e4"});
        expectOut(r + 5, 2, 1, 0, 0, 0, {name, ".e5"});
        expectOut(r + 6, 3, 1, 0, 0, 0, {name, ".e6"});
        expectOut(r + 21, 3, 1, 0, 0, 0, {name, ".e21"});
        expectOut(r + 22, 4, 0, 0, 1, 0, {name, ".e22"});
        expectAt(r + 22, SIG_RETRY, 0, {name, ".retry"});
    endtask

    initial begin
        int r, d;

        // Reset with both locks already high, then nominal bring-up.
        applyStimulus(1'b1, 1'b1, 1'b1);
        step(5);
        expectOut(cyc, 0, 1, 0, 0, 0, "reset");
        expectAt(cyc, SIG_RETRY, 0, "reset.retry");
        expectAt(cyc, SIG_LOST, 0, "reset.lost");
        applyStimulus(1'b0, 1'b1, 1'b1);
        r = cyc;
        expectNominal(r, "nominal");
        stepTo(r + 23);

        // Steady-lock drop alone is ignored in RUN.
        d = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectOut(d + 4, 4, 0, 0, 1, 0, "stdy_only");
        expectAt(d + 8, SIG_STATE, 4, "stdy_only.after");
        step(5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        stepTo(d + 10);

        // Loss of lock in RUN, then re-lock.
        d = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut(d + 2, 4, 0, 0, 1, 0, "loss.pre");
        expectOut(d + 3, 1, 1, 1, 0, 0, "loss");
        expectAt(d + 3, SIG_LOST, 1, "loss.lost");
        step(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectAt(d + 23, SIG_STATE, 3, "relock.hold");
        expectOut(d + 24, 4, 0, 0, 1, 0, "relock");
        expectAt(d + 24, SIG_LOST, 1, "relock.lost");
        stepTo(d + 26);

        // Loss, then a one-cycle glitch 8 cycles into HOLD forces a full new hold.
        d = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectAt(d + 3, SIG_STATE, 1, "loss2");
        expectAt(d + 3, SIG_LOST, 2, "loss2.lost");
        step(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectAt(d + 8, SIG_STATE, 3, "glitch.hold_entry");
        expectAt(d + 18, SIG_STATE, 3, "glitch.pre");
        expectOut(d + 19, 2, 1, 0, 0, 0, "glitch.wait");
        expectOut(d + 20, 3, 1, 0, 0, 0, "glitch.rehold");
        expectAt(d + 20, SIG_RETRY, 0, "glitch.retry");
        expectOut(d + 35, 3, 1, 0, 0, 0, "glitch.hold_end");
        expectOut(d + 36, 4, 0, 0, 1, 0, "glitch.run");
        expectAt(d + 36, SIG_LOST, 2, "glitch.lost");
        stepTo(d + 16);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        stepTo(d + 38);

        // Reset pulse while in HOLD, then the nominal timing repeats.
        d = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectAt(d + 3, SIG_LOST, 3, "loss3.lost");
        step(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectAt(d + 8, SIG_STATE, 3, "midrst.hold");
        stepTo(d + 10);
        applyStimulus(1'b1, 1'b1, 1'b1);
        step(1);
        expectOut(cyc, 0, 1, 0, 0, 0, "midrst");
        expectAt(cyc, SIG_LOST, 0, "midrst.lost");
        expectAt(cyc, SIG_RETRY, 0, "midrst.retry");
        applyStimulus(1'b0, 1'b1, 1'b1);
        r = cyc;
        expectNominal(r, "renominal");
        stepTo(r + 23);

        // Timeout exhaustion with locks held low.
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        r = cyc;
        expectOut(r + 1, 1, 1, 1, 0, 0, "tmo.p1");
        expectOut(r + 5, 2, 1, 0, 0, 0, "tmo.w1");
        expectAt(r + 68, SIG_STATE, 2, "tmo.w1_end");
        expectAt(r + 68, SIG_RETRY, 0, "tmo.w1_retry");
        expectOut(r + 69, 1, 1, 1, 0, 0, "tmo.p2");
        expectAt(r + 69, SIG_RETRY, 1, "tmo.p2_retry");
        expectAt(r + 72, SIG_STDY, 1, "tmo.p2_end");
        expectAt(r + 73, SIG_STDY, 0, "tmo.w2");
        expectOut(r + 137, 1, 1, 1, 0, 0, "tmo.p3");
        expectAt(r + 137, SIG_RETRY, 2, "tmo.p3_retry");
        expectOut(r + 205, 1, 1, 1, 0, 0, "tmo.p4");
        expectAt(r + 205, SIG_RETRY, 3, "tmo.p4_retry");
        expectAt(r + 272, SIG_STATE, 2, "tmo.w4_end");
        expectOut(r + 273, 5, 1, 0, 0, 1, "tmo.fail");
        expectAt(r + 273, SIG_RETRY, 3, "tmo.fail_retry");
        stepTo(r + 280);
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectOut(r + 310, 5, 1, 0, 0, 1, "tmo.sticky");
        stepTo(r + 312);

        // Late lock during the second attempt.
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        r = cyc;
        expectAt(r + 102, SIG_STATE, 2, "late.wait");
        expectAt(r + 102, SIG_RETRY, 1, "late.wait_retry");
        expectAt(r + 103, SIG_STATE, 3, "late.hold");
        expectAt(r + 103, SIG_RETRY, 1, "late.hold_retry");
        expectOut(r + 118, 3, 1, 0, 0, 0, "late.hold_end");
        expectAt(r + 118, SIG_RETRY, 1, "late.hold_end_retry");
        expectOut(r + 119, 4, 0, 0, 1, 0, "late.run");
        expectAt(r + 119, SIG_RETRY, 0, "late.run_retry");
        stepTo(r + 100);
        applyStimulus(1'b0, 1'b1, 1'b1);
        stepTo(r + 121);

        // 256 forced losses: lost_cnt saturates at 255.
        for (int i = 0; i < 256; i++) begin
            d = cyc;
            applyStimulus(1'b0, 1'b0, 1'b1);
            expectAt(d + 3, SIG_STATE, 1, "sat.loss");
            expectAt(d + 3, SIG_LOST, (i + 1 > 255) ? 255 : i + 1, "sat.lost");
            expectAt(d + 24, SIG_STATE, 4, "sat.run");
            step(3);
            applyStimulus(1'b0, 1'b1, 1'b1);
            stepTo(d + 26);
        end

        step(3);
        foreach (sb_q[k]) begin
            n_checks++;
            $display("[TB] FAIL %s @cycle %0d: still pending, expected %0d",
                     sb_q[k].name, sb_q[k].cyc, sb_q[k].val);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
